// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, reads the combinational instruction port
// and buffers fetched words in a 2-entry queue toward decode (valid/ready).
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    entry_t      q [2];
    logic        head;
    logic        tail;
    logic [1:0]  count;
    logic [31:0] pc;
    logic        pop;
    logic        push;

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    // A pop frees a slot in the same cycle, so a full queue still streams at one word per cycle.
    assign push      = !redirect_valid && ((count != 2'd2) || pop);
    assign imem_addr = {2'b00, pc[31:2]};
    assign out_instr = q[head].instr;
    assign out_pc    = q[head].pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC_ALIGNED;
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
            q[0]  <= '0;
            q[1]  <= '0;
        end else if (redirect_valid) begin
            // Flush: the head is discarded rather than consumed, even if out_ready is high.
            pc    <= {redirect_pc[31:2], 2'b00};
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else begin
            if (push) begin
                q[tail] <= '{pc: pc, instr: imem_data};
                tail    <= ~tail;
                pc      <= pc + 32'd4;
            end
            if (pop) begin
                head <= ~head;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: stream, backpressure, flush, full push/pop,
// PC wrap and asynchronous reset, against hand-computed values.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_ready     (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: words 0..3 hold 11,22,33,44; every other word is A5 followed by its low 24 index bits.
    always_comb begin
        if (imem_addr < 32'd4) imem_data = (imem_addr + 32'd1) * 32'h11;
        else                   imem_data = {8'hA5, imem_addr[23:0]};
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_instr [4];
        exp_instr[0] = 32'h11; exp_instr[1] = 32'h22;
        exp_instr[2] = 32'h33; exp_instr[3] = 32'h44;
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b addr=%h pc=%h instr=%h, required 0/0/0/0",
                     out_valid, imem_addr, out_pc, out_instr);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_instr !== exp_instr[i]) begin
                n_fail++;
                $display("FAIL stream[%0d]: valid=%b pc=%h instr=%h, required 1/%h/%h",
                         i, out_valid, out_pc, out_instr, 32'(4 * i), exp_instr[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_addr;
        out_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            exp_addr = (k == 0) ? 32'd1 : 32'd2;
            n_tests++;
            if (out_valid !== 1'b1 || out_pc !== 32'h0 || imem_addr !== exp_addr) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: valid=%b pc=%h addr=%h, required 1/0/%h",
                         k, out_valid, out_pc, imem_addr, exp_addr);
            end
        end
        out_ready = 1'b1;
        for (int j = 1; j < 4; j++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * j)) begin
                n_fail++;
                $display("FAIL backpressure_release[%0d]: valid=%b pc=%h, required 1/%h",
                         j, out_valid, out_pc, 32'(4 * j));
            end
        end
    endtask

    task automatic test_push_pop_full();
        out_ready = 1'b0;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_instr !== 32'h22 || imem_addr !== 32'd3) begin
                n_fail++;
                $display("FAIL push_pop_full[%0d]: valid=%b pc=%h instr=%h addr=%h, required 1/4/22/3",
                         k, out_valid, out_pc, out_instr, imem_addr);
            end
            if (k < 2) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (out_pc !== 32'h8 || out_instr !== 32'h33) begin
            n_fail++;
            $display("FAIL push_pop_drain0: pc=%h instr=%h, required 8/33", out_pc, out_instr);
        end
        @(negedge clk);
        n_tests++;
        if (out_pc !== 32'hC || out_instr !== 32'h44) begin
            n_fail++;
            $display("FAIL push_pop_drain1: pc=%h instr=%h, required c/44", out_pc, out_instr);
        end
    endtask

    task automatic test_redirect();
        out_ready = 1'b0;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0043;
        out_ready      = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL redirect_flush: valid=%b addr=%h, required 0/10", out_valid, imem_addr);
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== 32'hA500_0010) begin
            n_fail++;
            $display("FAIL redirect_target: valid=%b pc=%h instr=%h, required 1/40/a5000010",
                     out_valid, out_pc, out_instr);
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h44 || out_instr !== 32'hA500_0011) begin
            n_fail++;
            $display("FAIL redirect_next: valid=%b pc=%h instr=%h, required 1/44/a5000011",
                     out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_wrap();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h3FFF_FFFF) begin
            n_fail++;
            $display("FAIL wrap_addr: valid=%b addr=%h, required 0/3fffffff", out_valid, imem_addr);
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC || out_instr !== 32'hA5FF_FFFF || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_last: valid=%b pc=%h instr=%h addr=%h, required 1/fffffffc/a5ffffff/0",
                     out_valid, out_pc, out_instr, imem_addr);
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h11 || imem_addr !== 32'h1) begin
            n_fail++;
            $display("FAIL wrap_zero: valid=%b pc=%h instr=%h addr=%h, required 1/0/11/1",
                     out_valid, out_pc, out_instr, imem_addr);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b addr=%h pc=%h instr=%h, required 0/0/0/0",
                     out_valid, imem_addr, out_pc, out_instr);
        end
        // A redirect while reset is held must have no effect.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0080;
        @(negedge clk);
        @(negedge clk);
        redirect_valid = 1'b0;
        rst_n          = 1'b1;
        out_ready      = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * i)) begin
                n_fail++;
                $display("FAIL async_restart[%0d]: valid=%b pc=%h, required 1/%h",
                         i, out_valid, out_pc, 32'(4 * i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_push_pop_full();
        test_redirect();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
